axis_pkt_gen: RTL and testbench



---
 rtl/axis_pkt_gen.sv | 177 +++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// Command-driven AXI4-Stream packet generator: one incrementing-pattern packet per accepted command.
// Optional packet/byte statistics are built only when AXIS_PKT_GEN_STATS_EN is defined.
module axis_pkt_gen #(
   parameter int DATA_WIDTH = 512,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic [31:0]             cmd_seed,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic [31:0]             pkt_count,
   output logic [47:0]             byte_count
);

   localparam int B = DATA_WIDTH / 8;
   localparam int L = DATA_WIDTH / 32;
   localparam logic [31:0]          B_W   = 32'(B);
   localparam logic [31:0]          L_W   = 32'(L);
   localparam logic [LEN_WIDTH-1:0] B_LEN = LEN_WIDTH'(B);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [31:0]           base_q, base_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [B-1:0]          tkeep_q, tkeep_d;
   logic                  tlast_q, tlast_d;

   logic                  accept;
   logic                  beat_hs;
   logic                  load;
   logic [31:0]           nxt_base;
   logic [LEN_WIDTH-1:0]  nxt_rem;
   logic [31:0]           nxt_rem32;
   logic [DATA_WIDTH-1:0] beat_data;
   logic [B-1:0]          beat_keep;
   logic                  beat_last;

   assign cmd_ready = (state_q == IDLE) && !areset;
   assign accept    = cmd_ready && cmd_valid && (cmd_len != '0);
   assign beat_hs   = tvalid_q && m_axis_tready;

   // rem is the byte count still owed, including the beat being built.
   always_comb begin
      nxt_base = base_q + L_W;
      nxt_rem  = rem_q - B_LEN;
      if (state_q == IDLE) begin
         nxt_base = cmd_seed;
         nxt_rem  = cmd_len;
      end
      nxt_rem32 = 32'(nxt_rem);
   end

   always_comb begin
      beat_data = '0;
      beat_keep = '0;
      for (int i = 0; i < L; i++) begin
         beat_data[32*i +: 32] = nxt_base + 32'(i);
      end
      for (int j = 0; j < B; j++) begin
         beat_keep[j] = (32'(j) < nxt_rem32);
         if (32'(j) >= nxt_rem32) begin
            beat_data[8*j +: 8] = 8'h00;
         end
      end
      beat_last = (nxt_rem32 <= B_W);
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      rem_d    = rem_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tlast_d  = tlast_q;
      load     = 1'b0;
      if (state_q == IDLE) begin
         if (accept) begin
            state_d = SEND;
            load    = 1'b1;
         end
      end else if (beat_hs) begin
         if (tlast_q) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
         end else begin
            load = 1'b1;
         end
      end
      if (load) begin
         base_d   = nxt_base;
         rem_d    = nxt_rem;
         tvalid_d = 1'b1;
         tdata_d  = beat_data;
         tkeep_d  = beat_keep;
         tlast_d  = beat_last;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         rem_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         rem_q    <= rem_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tkeep_q  <= tkeep_d;
         tlast_q  <= tlast_d;
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tlast  = tlast_q;

`ifdef AXIS_PKT_GEN_STATS_EN
   logic [LEN_WIDTH-1:0] len_q;
   logic [31:0]          pkt_q, pkt_d;
   logic [47:0]          bytes_q, bytes_d;
   logic                 pkt_done;

   assign pkt_done = (state_q == SEND) && beat_hs && tlast_q;

   always_comb begin
      pkt_d   = pkt_q;
      bytes_d = bytes_q;
      if (pkt_done) begin
         pkt_d   = pkt_q + 32'd1;
         bytes_d = bytes_q + 48'(len_q);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         len_q   <= '0;
         pkt_q   <= '0;
         bytes_q <= '0;
      end else begin
         if (accept) begin
            len_q <= cmd_len;
         end
         pkt_q   <= pkt_d;
         bytes_q <= bytes_d;
      end
   end

   assign pkt_count  = pkt_q;
   assign byte_count = bytes_q;
`else
   assign pkt_count  = '0;
   assign byte_count = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: command driver pushes model beats, a negedge monitor pops and compares.
module tb_axis_pkt_gen;

   localparam int DW = 512;
   localparam int LW = 16;
   localparam int B  = DW / 8;
   localparam int L  = DW / 32;

   logic          aclk;
   logic          areset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len;
   logic [31:0]   cmd_seed;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [B-1:0]  m_axis_tkeep;
   logic          m_axis_tlast;
   logic [31:0]   pkt_count;
   logic [47:0]   byte_count;

   axis_pkt_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_len       (cmd_len),
      .cmd_seed      (cmd_seed),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .pkt_count     (pkt_count),
      .byte_count    (byte_count)
   );

   // clock / reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic [DW-1:0] data;
      logic [B-1:0]  keep;
      logic          last;
      int            len;
   } beat_t;

   beat_t       exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_pkt = 0;
   logic [47:0] exp_bytes = '0;
   int          beats_seen = 0;
   int          gap_run = 0;
   int          last_gap = -1;
   bit          gap_count = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_w(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_counters(input string name);
`ifdef AXIS_PKT_GEN_STATS_EN
      check({name, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
      check({name, "_byte_count"}, 64'(byte_count), 64'(exp_bytes));
`else
      check({name, "_pkt_count"}, 64'(pkt_count), 64'd0);
      check({name, "_byte_count"}, 64'(byte_count), 64'd0);
`endif
   endtask

   // reference model: packet expressed as a list of beats from byte/lane arithmetic
   task automatic push_pkt(input int len, input logic [31:0] seed);
      int    n;
      beat_t b;
      logic [31:0] lane;
      n = (len + B - 1) / B;
      for (int k = 0; k < n; k++) begin
         b.data = '0;
         b.keep = '0;
         for (int i = 0; i < L; i++) begin
            lane = seed + 32'(k * L + i);
            for (int jj = 0; jj < 4; jj++) begin
               if (k * B + 4 * i + jj < len) begin
                  b.keep[4*i + jj]        = 1'b1;
                  b.data[32*i + 8*jj +: 8] = lane[8*jj +: 8];
               end
            end
         end
         b.last = (k == n - 1);
         b.len  = len;
         exp_q.push_back(b);
      end
   endtask

   // driver tasks
   task automatic send_cmd(input int len, input logic [31:0] seed);
      int t = 0;
      @(posedge aclk); #1;
      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
      cmd_seed  = seed;
      while (t < 5000) begin
         @(negedge aclk);
         if (cmd_ready) break;
         t++;
      end
      if (t >= 5000) begin
         checks++;
         errors++;
         $display("FAIL cmd_accept_timeout len=%0d", len);
      end else begin
         push_pkt(len, seed);
      end
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
      cmd_len   = LW'($urandom);
      cmd_seed  = $urandom;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (t < 20000) begin
         @(posedge aclk); #2;
         if (exp_q.size() == 0 && !m_axis_tvalid && cmd_ready) break;
         t++;
      end
      if (t >= 20000) begin
         checks++;
         errors++;
         $display("FAIL %s drain_timeout pending=%0d", name, exp_q.size());
      end
      check_counters(name);
   endtask

   int   ready_mode = 0;
   int   pat_idx = 0;
   logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge aclk); #1;
         case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 2) != 0);
            default: begin
               m_axis_tready = pat[pat_idx % 6];
               pat_idx++;
            end
         endcase
      end
   end

   // monitor / scoreboard
   logic          prev_valid = 1'b0;
   logic          prev_hs = 1'b0;
   logic          prev_last_hs = 1'b0;
   logic [DW-1:0] prev_data;
   logic [B-1:0]  prev_keep;
   logic          prev_last;
   beat_t         e;

   always @(negedge aclk) begin
      if (areset) begin
         prev_valid   = 1'b0;
         prev_hs      = 1'b0;
         prev_last_hs = 1'b0;
         gap_count    = 1'b0;
      end else begin
         if (prev_valid && !prev_hs) begin
            check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
            check_w("stall_tdata", m_axis_tdata, prev_data);
            check("stall_tkeep", 64'(m_axis_tkeep), 64'(prev_keep));
            check("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
         end
         if (prev_last_hs) begin
            check("gap_after_last", 64'(m_axis_tvalid), 64'd0);
            gap_count = 1'b1;
            gap_run   = 0;
         end
         if (gap_count) begin
            if (m_axis_tvalid) begin
               last_gap  = gap_run;
               gap_count = 1'b0;
            end else begin
               gap_run++;
            end
         end
         if (m_axis_tvalid) check("cmd_ready_in_send", 64'(cmd_ready), 64'd0);
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat got_tdata=%0h exp=none", m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               check_w("beat_tdata", m_axis_tdata, e.data);
               check("beat_tkeep", 64'(m_axis_tkeep), 64'(e.keep));
               check("beat_tlast", 64'(m_axis_tlast), 64'(e.last));
               beats_seen++;
               if (e.last) begin
                  exp_pkt++;
                  exp_bytes = exp_bytes + 48'(e.len);
               end
            end
         end
         prev_valid   = m_axis_tvalid;
         prev_data    = m_axis_tdata;
         prev_keep    = m_axis_tkeep;
         prev_last    = m_axis_tlast;
         prev_hs      = m_axis_tvalid && m_axis_tready;
         prev_last_hs = prev_hs && m_axis_tlast;
      end
   end

   int base_beats;

   initial begin
      areset    = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_seed  = '0;
      repeat (2) @(negedge aclk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_w("rst_tdata", m_axis_tdata, '0);
      check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      check("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check_counters("rst");
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

      // single full beat, then a partial last beat
      send_cmd(64, 32'h0);
      wait_idle("len64");
      send_cmd(100, 32'h10);
      wait_idle("len100");

      // stalls under a fixed ready pattern
      ready_mode = 2;
      pat_idx    = 0;
      send_cmd(192, $urandom);
      wait_idle("len192_stall");
      ready_mode = 0;

      // zero-length command is consumed with no beats
      send_cmd(0, 32'h1234);
      repeat (3) begin
         @(negedge aclk);
         check("len0_tvalid", 64'(m_axis_tvalid), 64'd0);
         check("len0_cmd_ready", 64'(cmd_ready), 64'd1);
      end
      check_counters("len0");

      send_cmd(64, 32'h100);
      send_cmd(64, 32'h200);
      wait_idle("back_to_back");
      check("b2b_gap_cycles", 64'(last_gap), 64'd1);

      send_cmd(64, 32'hFFFF_FFF8);
      wait_idle("seed_wrap");

      send_cmd(65535, $urandom);
      wait_idle("len_max");

      // reset in the middle of a packet
      send_cmd(256, 32'h55);
      base_beats = beats_seen;
      for (int t = 0; t < 100; t++) begin
         @(posedge aclk);
         if (beats_seen >= base_beats + 2) break;
      end
      #2;
      areset = 1'b1;
      #1;
      check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("midrst_pkt_count", 64'(pkt_count), 64'd0);
      check("midrst_byte_count", 64'(byte_count), 64'd0);
      check("midrst_beats_seen", 64'(beats_seen - base_beats), 64'd2);
      exp_q.delete();
      exp_pkt   = 0;
      exp_bytes = '0;
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      check("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
      send_cmd(64, 32'hABCD_0000);
      wait_idle("postrst_len64");

      // randomized traffic with random backpressure
      ready_mode = 1;
      for (int p = 0; p < 25; p++) begin
         if ($urandom_range(0, 3) == 0) send_cmd($urandom_range(0, 130), $urandom);
         else                          send_cmd($urandom_range(1, 1000), $urandom);
      end
      wait_idle("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
